// File: rtl/systolic_pkg.sv
// Parameters shared by the systolic PE, the array top and the result collector.
package systolic_pkg;

  localparam int SUM_W   = 16;
  localparam int COLS    = 4;
  localparam int SLICE_W = SUM_W;

  // Width of a counter that indexes n items; never zero so a 1-entry range still has a bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_result_collector_fifo.sv
// First-word fall-through row buffer with occupancy count; the head word reads as zero when empty.
module result_fifo
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a full buffer still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// De-skews the staggered bottom-row column sums of the systolic array into aligned rows,
// buffers them and streams them out with tile framing and an early stall request.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int COLS          = systolic_pkg::COLS,
  parameter int SUM_W         = systolic_pkg::SUM_W,
  parameter int DEPTH         = 8,
  parameter int ROWS_PER_TILE = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  active,
  input  logic [COLS*SUM_W-1:0] colsum,
  input  logic [COLS-1:0]       colvalid,
  output logic [COLS*SUM_W-1:0] row_data,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic                  row_last,
  output logic                  stall_req,
  output logic                  overflow,
  output logic                  skew_err
);

  localparam int ROW_W = COLS * SUM_W;
  localparam int IDX_W = idx_width(ROWS_PER_TILE);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [SUM_W-1:0]       aligned_sum [COLS];
  logic [COLS-1:0]        aligned_vld;
  logic [ROW_W-1:0]       aligned_row;
  logic                   push_req;
  logic                   skew_hit;
  logic                   pop;
  logic                   accepted;
  logic [IDX_W-1:0]       tile_idx;
  logic [IDX_W-1:0]       head_idx;
  logic [IDX_W+ROW_W-1:0] fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [CNT_W-1:0]       fifo_count;

  // Column j arrives j cycles after column 0, so it gets COLS-j stages to line up.
  for (genvar j = 0; j < COLS; j++) begin : g_deskew
    localparam int STAGES = COLS - j;
    logic [SUM_W-1:0]  sum_q [STAGES];
    logic [STAGES-1:0] vld_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int k = 0; k < STAGES; k++) begin
          sum_q[k] <= '0;
        end
        vld_q <= '0;
      end else if (active) begin
        sum_q[0] <= colsum[j*SUM_W +: SUM_W];
        vld_q[0] <= colvalid[j];
        for (int k = 1; k < STAGES; k++) begin
          sum_q[k] <= sum_q[k-1];
          vld_q[k] <= vld_q[k-1];
        end
      end
    end

    assign aligned_sum[j] = sum_q[STAGES-1];
    assign aligned_vld[j] = vld_q[STAGES-1];
  end

  always_comb begin
    aligned_row = '0;
    for (int j = 0; j < COLS; j++) begin
      aligned_row[j*SUM_W +: SUM_W] = aligned_sum[j];
    end
  end

  assign push_req = active && (&aligned_vld);
  assign skew_hit = active && (|aligned_vld) && !(&aligned_vld);
  assign pop      = row_valid && row_ready;
  assign accepted = push_req && (!fifo_full || pop);

  result_fifo #(
    .WIDTH (IDX_W + ROW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .din   ({tile_idx, aligned_row}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign row_valid = !fifo_empty;
  assign row_data  = fifo_dout[ROW_W-1:0];
  assign head_idx  = fifo_dout[ROW_W +: IDX_W];
  assign row_last  = row_valid && (head_idx == IDX_W'(ROWS_PER_TILE - 1));

  // Stall headroom of COLS rows covers everything already travelling through the delay lines.
  always_ff @(posedge clock) begin
    if (reset) begin
      tile_idx  <= '0;
      overflow  <= 1'b0;
      skew_err  <= 1'b0;
      stall_req <= 1'b0;
    end else begin
      if (accepted) begin
        tile_idx <= (tile_idx == IDX_W'(ROWS_PER_TILE - 1)) ? '0 : tile_idx + 1'b1;
      end
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      if (skew_hit) begin
        skew_err <= 1'b1;
      end
      stall_req <= (fifo_count >= CNT_W'(DEPTH - COLS));
    end
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Scoreboard bench for the result collector: drives staggered column sums and checks aligned rows.
module tb_systolic_result_collector;
  import systolic_pkg::*;

  localparam int NC      = 4;
  localparam int W       = 16;
  localparam int DEPTH   = 8;
  localparam int RPT     = 4;
  localparam int ROW_W   = NC * W;
  localparam int MAXSTEP = 512;

  logic             clock;
  logic             reset;
  logic             active;
  logic             row_ready;
  logic [ROW_W-1:0] colsum;
  logic [NC-1:0]    colvalid;
  logic [ROW_W-1:0] row_data;
  logic             row_valid;
  logic             row_last;
  logic             stall_req;
  logic             overflow;
  logic             skew_err;

  systolic_result_collector #(
    .COLS          (NC),
    .SUM_W         (W),
    .DEPTH         (DEPTH),
    .ROWS_PER_TILE (RPT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .active    (active),
    .colsum    (colsum),
    .colvalid  (colvalid),
    .row_data  (row_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_last  (row_last),
    .stall_req (stall_req),
    .overflow  (overflow),
    .skew_err  (skew_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [ROW_W-1:0] data;
    logic             last;
    int               due;
  } exp_row_t;

  exp_row_t exp_q[$];

  // Stimulus is indexed by array step, which only advances on active cycles.
  logic [W-1:0]     stim_sum  [NC][MAXSTEP];
  logic             stim_vld  [NC][MAXSTEP];
  logic             done_row  [MAXSTEP];
  logic [ROW_W-1:0] done_data [MAXSTEP];
  logic [NC-1:0]    done_mask [MAXSTEP];

  int         step;
  int         cyc;
  int         model_idx;
  int         rows_seen;
  int         first_valid_cyc;
  int         watch_step;
  int         watch_cyc;
  int         assert_count;
  int         fail_count;
  logic       exp_overflow;
  logic       exp_skew;
  logic       strict_timing;
  logic [7:0] last_hist;
  logic [ROW_W-1:0] tile_rows [5];

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic scheduleRow(input int s, input logic [ROW_W-1:0] data, input logic [NC-1:0] mask);
    for (int j = 0; j < NC; j++) begin
      stim_sum[j][s+j] = data[j*W +: W];
      stim_vld[j][s+j] = mask[j];
    end
    done_row[s+NC-1]  = 1'b1;
    done_data[s+NC-1] = data;
    done_mask[s+NC-1] = mask;
  endtask

  // Reference behaviour, evaluated when a row's last column is driven.
  task automatic modelRow(input int s);
    exp_row_t e;
    if (&done_mask[s]) begin
      if (exp_q.size() >= DEPTH) begin
        exp_overflow = 1'b1;
      end else begin
        e.data = done_data[s];
        e.last = (model_idx == RPT - 1);
        e.due  = cyc + 2;
        exp_q.push_back(e);
        model_idx = (model_idx == RPT - 1) ? 0 : model_idx + 1;
      end
    end else if (|done_mask[s]) begin
      exp_skew = 1'b1;
    end
  endtask

  task automatic monitorOutputs();
    exp_row_t e;
    if (row_valid && row_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_row", 128'(row_valid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("row_data", 128'(row_data), 128'(e.data));
        checkOutput("row_last", 128'(row_last), 128'(e.last));
        if (strict_timing) checkOutput("row_cycle", 128'(cyc), 128'(e.due));
        if (rows_seen == 0) first_valid_cyc = cyc;
        if (rows_seen < 8) last_hist[rows_seen] = row_last;
        rows_seen++;
      end
    end
  endtask

  task automatic applyStimulus(input logic act, input logic rdy);
    @(posedge clock);
    #1;
    cyc++;
    active    = act;
    row_ready = rdy;
    if (act) begin
      for (int j = 0; j < NC; j++) begin
        colsum[j*W +: W] = stim_sum[j][step];
        colvalid[j]      = stim_vld[j][step];
      end
      if (step == watch_step) watch_cyc = cyc;
      if (done_row[step]) modelRow(step);
      step++;
    end
    @(negedge clock);
    monitorOutputs();
  endtask

  task automatic resetDut();
    @(posedge clock);
    #1;
    cyc++;
    reset     = 1'b1;
    active    = 1'b0;
    row_ready = 1'b0;
    colvalid  = '0;
    colsum    = '0;
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b0;
    exp_q.delete();
    model_idx    = 0;
    exp_overflow = 1'b0;
    exp_skew     = 1'b0;
    for (int k = step; k < MAXSTEP; k++) begin
      done_row[k] = 1'b0;
      for (int j = 0; j < NC; j++) begin
        stim_sum[j][k] = '0;
        stim_vld[j][k] = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int s;
    logic [ROW_W-1:0] d;

    assert_count = 0;
    fail_count   = 0;
    step = 0;
    cyc = 0;
    model_idx = 0;
    rows_seen = 0;
    first_valid_cyc = 0;
    watch_step = -1;
    watch_cyc = -1;
    exp_overflow = 1'b0;
    exp_skew = 1'b0;
    strict_timing = 1'b1;
    last_hist = '0;
    reset = 1'b1;
    active = 1'b0;
    row_ready = 1'b0;
    colsum = '0;
    colvalid = '0;
    for (int k = 0; k < MAXSTEP; k++) begin
      done_row[k]  = 1'b0;
      done_data[k] = '0;
      done_mask[k] = '0;
      for (int j = 0; j < NC; j++) begin
        stim_sum[j][k] = '0;
        stim_vld[j][k] = 1'b0;
      end
    end
    tile_rows[0] = {16'h8000, 16'hFFFF, 16'h0001, 16'h7FFF};
    tile_rows[1] = {16'hFFFF, 16'h8000, 16'h1234, 16'h0000};
    tile_rows[2] = {16'h0001, 16'h0002, 16'hFFFE, 16'h8001};
    tile_rows[3] = {16'hABCD, 16'h8000, 16'hFFFF, 16'h0F0F};
    tile_rows[4] = {16'h5555, 16'hAAAA, 16'h8000, 16'hFFFF};
    repeat (2) @(posedge clock);

    $display("[TB] reset then idle");
    resetDut();
    checkOutput("reset_row_valid", 128'(row_valid), 128'(0));
    checkOutput("reset_row_data", 128'(row_data), 128'(0));
    repeat (20) applyStimulus(1'b1, 1'b1);
    checkOutput("idle_row_valid", 128'(row_valid), 128'(0));
    checkOutput("idle_row_last", 128'(row_last), 128'(0));
    checkOutput("idle_stall_req", 128'(stall_req), 128'(0));
    checkOutput("idle_overflow", 128'(overflow), 128'(0));
    checkOutput("idle_skew_err", 128'(skew_err), 128'(0));

    $display("[TB] single skewed row");
    resetDut();
    rows_seen = 0;
    s = step;
    watch_step = s;
    scheduleRow(s, {16'h0103, 16'h0102, 16'h0101, 16'h0100}, 4'hF);
    repeat (12) applyStimulus(1'b1, 1'b1);
    checkOutput("skewed_rows_seen", 128'(rows_seen), 128'(1));
    checkOutput("skewed_latency", 128'(first_valid_cyc - watch_cyc), 128'(NC + 1));
    checkOutput("skewed_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] tile of back-to-back rows");
    resetDut();
    rows_seen = 0;
    last_hist = '0;
    s = step;
    for (int r = 0; r < 5; r++) scheduleRow(s + r, tile_rows[r], 4'hF);
    repeat (15) applyStimulus(1'b1, 1'b1);
    checkOutput("tile_rows_seen", 128'(rows_seen), 128'(5));
    checkOutput("tile_last_pattern", 128'(last_hist), 128'(8'b0000_1000));
    checkOutput("tile_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] backpressure and overflow");
    resetDut();
    strict_timing = 1'b0;
    rows_seen = 0;
    s = step;
    watch_step = s + NC - 1;
    watch_cyc = -1;
    for (int r = 0; r < 9; r++) begin
      for (int j = 0; j < NC; j++) d[j*W +: W] = W'($urandom);
      scheduleRow(s + r, d, 4'hF);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (watch_cyc >= 0) begin
        if (cyc == watch_cyc + 5) checkOutput("stall_before_rise", 128'(stall_req), 128'(0));
        if (cyc == watch_cyc + 6) checkOutput("stall_rise", 128'(stall_req), 128'(1));
        if (cyc == watch_cyc + 9) checkOutput("overflow_before_drop", 128'(overflow), 128'(0));
      end
    end
    checkOutput("bp_row_valid", 128'(row_valid), 128'(1));
    checkOutput("bp_stall_held", 128'(stall_req), 128'(1));
    checkOutput("bp_overflow", 128'(overflow), 128'(1));
    checkOutput("bp_overflow_model", 128'(overflow), 128'(exp_overflow));
    repeat (20) applyStimulus(1'b1, 1'b1);
    checkOutput("drain_rows_seen", 128'(rows_seen), 128'(8));
    checkOutput("drain_queue_empty", 128'(exp_q.size()), 128'(0));
    checkOutput("drain_stall_clear", 128'(stall_req), 128'(0));
    checkOutput("drain_overflow_sticky", 128'(overflow), 128'(1));

    $display("[TB] array stall mid-row");
    resetDut();
    strict_timing = 1'b1;
    rows_seen = 0;
    s = step;
    watch_step = s;
    scheduleRow(s, {16'h4444, 16'hC333, 16'h2222, 16'hF111}, 4'hF);
    repeat (2) applyStimulus(1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat (15) applyStimulus(1'b1, 1'b1);
    checkOutput("stall_rows_seen", 128'(rows_seen), 128'(1));
    checkOutput("stall_latency", 128'(first_valid_cyc - watch_cyc), 128'(NC + 1 + 3));
    checkOutput("stall_skew_err", 128'(skew_err), 128'(0));

    $display("[TB] skew fault then mid-stream reset");
    resetDut();
    rows_seen = 0;
    s = step;
    scheduleRow(s, {16'hDEAD, 16'hBEEF, 16'h0BAD, 16'hF00D}, 4'b1011);
    scheduleRow(s + 1, {16'h1357, 16'h9BDF, 16'h2468, 16'hACE0}, 4'hF);
    repeat (12) applyStimulus(1'b1, 1'b1);
    checkOutput("skew_err_set", 128'(skew_err), 128'(1));
    checkOutput("skew_err_model", 128'(skew_err), 128'(exp_skew));
    checkOutput("skew_rows_seen", 128'(rows_seen), 128'(1));
    strict_timing = 1'b0;
    s = step;
    for (int r = 0; r < 3; r++) scheduleRow(s + r, {16'h0A00, 16'h0B00, 16'h0C00, 16'(r)}, 4'hF);
    repeat (10) applyStimulus(1'b1, 1'b0);
    checkOutput("buffered_row_valid", 128'(row_valid), 128'(1));
    resetDut();
    checkOutput("midreset_row_valid", 128'(row_valid), 128'(0));
    checkOutput("midreset_row_data", 128'(row_data), 128'(0));
    checkOutput("midreset_skew_err", 128'(skew_err), 128'(0));
    checkOutput("midreset_overflow", 128'(overflow), 128'(0));
    checkOutput("midreset_stall_req", 128'(stall_req), 128'(0));
    repeat (8) applyStimulus(1'b1, 1'b1);
    checkOutput("post_reset_idle", 128'(row_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Receiving end of the systolic MAC array's column-sum path.
- Bottom-row PEs emit partial sums staggered by one cycle per column: row r, column j appears at cycle t0+r+j. This block de-skews those columns into aligned result rows.
- Aligned rows are buffered in a small FIFO and presented on a valid/ready stream to the writeback/memory side.
- Generates a stall request so the array's `active` can be dropped before the buffer overflows.

Parameters:
- COLS, 4, number of array columns (>=2).
- SUM_W, 16, width of one column sum (signed, matches PE maccout).
- DEPTH, 8, FIFO depth in rows (power of 2, >= 2*COLS).
- ROWS_PER_TILE, 4, rows per output tile; drives row_last.

Ports:
- clock  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- active  in  1  array-global active; de-skew lines advance only when high.
- colsum  in  COLS*SUM_W  bottom-row maccout; column j at [j*SUM_W +: SUM_W].
- colvalid  in  COLS  bottom-row activeout qualifier per column.
- row_data  out  COLS*SUM_W  aligned result row; same column packing as colsum.
- row_valid  out  1  FIFO head holds a row.
- row_ready  in  1  consumer accepts the head row when row_valid&row_ready.
- row_last  out  1  head row is the final row of a tile.
- stall_req  out  1  request to drop array active; FIFO nearly full.
- overflow  out  1  sticky: a row was dropped because the FIFO was full.
- skew_err  out  1  sticky: aligned valids disagreed; that row was dropped.

Behaviour:
- Reset (synchronous, active-high, takes effect at the clock edge):
  - clears delay lines, FIFO pointers/count, tile row counter, overflow and skew_err.
  - row_valid=0, row_last=0, stall_req=0, row_data=0.
  - Applies mid-operation: in-flight and buffered rows are discarded.
- De-skew:
  - Column j passes through a registered delay line of COLS-j stages (column COLS-1: 1 stage; column 0: COLS stages), carrying both sum and valid.
  - When active=0, all delay lines hold their contents. When active=1, they shift.
- Row push:
  - Taken on an active cycle when all aligned valids are 1.
  - If aligned valids are mixed (some 1, some 0): set skew_err and push nothing.
  - If all aligned valids are 0: no action.
- Latency: with active held high, a row whose column COLS-1 is presented in cycle t is written at the edge ending cycle t+1. row_valid is high in cycle t+2. Throughput is one row per cycle.
- FIFO:
  - First-word fall-through; row_data and row_last are valid whenever row_valid=1.
  - Pop on row_valid&row_ready.
  - Push and pop on the same edge: both happen; count is unchanged, including when full.
  - Push when full with no pop: row dropped, overflow set, no pointer change.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
- stall_req = (count >= DEPTH-COLS). It is registered and updates one cycle after count changes. The headroom absorbs rows already in the de-skew lines.
- Tile tracking:
  - A row index (0..ROWS_PER_TILE-1) is stored with each pushed row. It increments per push and wraps to 0 after ROWS_PER_TILE-1.
  - row_last = stored index == ROWS_PER_TILE-1.
  - Dropped rows do not advance the index.
- Arithmetic: no arithmetic on sums; values pass bit-exact, signed SUM_W.
- Sticky flags clear only on reset.

Decomposition:
- Shared package (systolic_pkg): SUM_W, COLS defaults, and a localparam for the column slice width. This package is shared with the PE and array top.
- One natural sub-module: result_fifo (parameterised width/depth, FWFT, count output). Instantiate it once.
- De-skew lines are generated inline with a generate loop.

Test Plan:
- Reset then idle: colvalid=0 for 20 cycles -> row_valid=0, stall_req=0, overflow=0, skew_err=0.
- Skewed row: column j gets value 16'h0100+j with colvalid[j]=1 in cycle 10+j, active=1, row_ready=1 -> row_valid=1 in cycle 15 only; row_data={16'h0103,16'h0102,16'h0101,16'h0100}.
- Tile of 4 back-to-back rows, signed values incl. 16'h8000 and 16'hFFFF -> 4 consecutive valid rows, bit-exact; row_last=1 on the 4th row only; the 5th row has row_last=0.
- Backpressure: row_ready=0 while streaming 8 rows -> stall_req rises the cycle after count reaches 4; a 9th row sets overflow=1; releasing row_ready drains exactly 8 rows in order.
- Array stall: drop active for 3 cycles while a row is half-skewed -> the row emerges intact, delayed by 3 cycles; skew_err=0.
- Skew fault: colvalid[2] missing for one row -> skew_err=1, that row absent, the next row delivered correctly. Then reset mid-stream with 3 rows buffered -> row_valid=0 and flags cleared the next cycle.
